// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_control_unit
// Brief   : RV32I multicycle sequencer (FETCH/DECODE/EXEC/MEM/WB) with bounded
//           memory waits. Optional macro MCU_PERF_COUNTERS_EN adds
//           instret_cnt / stall_cnt outputs.
// Revision: 1.0
// ============================================================================
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT   = 16,
  parameter int CNT_W         = 8,
  parameter int RESET_PC_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] instr,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic [1:0] aluop,
  output logic       Branch,
  output logic       MemRead,
  output logic       MemtoReg,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       JALflag,
  output logic       JALRflag,
  output logic       pc_write,
  output logic       ir_write,
  output logic       halt,
  output logic       fault
`ifdef MCU_PERF_COUNTERS_EN
  ,
  output logic [31:0] instret_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_I    = 7'b0010011;
  localparam logic [6:0] c_OP_S    = 7'b0100011;
  localparam logic [6:0] c_OP_L    = 7'b0000011;
  localparam logic [6:0] c_OP_B    = 7'b1100011;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;
  localparam logic [6:0] c_OP_JALR = 7'b1100111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_S, C_L, C_B, C_JAL, C_JALR, C_BAD
  } cls_t;

  function automatic cls_t f_classify(input logic [6:0] op);
    case (op)
      c_OP_R:    return C_R;
      c_OP_I:    return C_I;
      c_OP_S:    return C_S;
      c_OP_L:    return C_L;
      c_OP_B:    return C_B;
      c_OP_JAL:  return C_JAL;
      c_OP_JALR: return C_JALR;
      default:   return C_BAD;
    endcase
  endfunction

  state_t           r_state;
  cls_t             r_cls;
  logic [2:0]       r_f3;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fault;

  cls_t w_cls;
  logic w_cnt_last;
  logic w_idle_done;
  logic w_taken;

  assign w_cls       = f_classify(instr);
  // Last permitted wait cycle; a ready in this same cycle still succeeds.
  assign w_cnt_last  = (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign w_idle_done = (RESET_PC_WAIT == 0) || (r_cnt == CNT_W'(RESET_PC_WAIT));
  assign w_taken     = ((r_f3 == 3'b000) && zero) || ((r_f3 == 3'b001) && !zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cls   <= C_BAD;
      r_f3    <= '0;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_idle_done) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_FETCH: begin
          if (imem_ready) begin
            r_state <= S_DECODE;
            r_cnt   <= '0;
          end else if (w_cnt_last) begin
            r_state <= S_HALT;
            r_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          r_cls <= w_cls;
          r_f3  <= funct3;
          r_cnt <= '0;
          if (w_cls == C_BAD) begin
            r_state <= S_HALT;
            r_fault <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_cnt <= '0;
          case (r_cls)
            C_L, C_S: r_state <= S_MEM;
            C_B:      r_state <= S_FETCH;
            default:  r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            r_state <= (r_cls == C_L) ? S_WB : S_FETCH;
            r_cnt   <= '0;
          end else if (w_cnt_last) begin
            r_state <= S_HALT;
            r_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
          r_cnt   <= '0;
        end
        S_HALT: r_state <= S_HALT;
        default: begin
          r_state <= S_HALT;
          r_fault <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    aluop    = 2'b00;
    Branch   = 1'b0;
    MemRead  = 1'b0;
    MemtoReg = 1'b0;
    MemWrite = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    JALflag  = 1'b0;
    JALRflag = 1'b0;
    pc_write = 1'b0;
    ir_write = 1'b0;
    halt     = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      S_EXEC: begin
        case (r_cls)
          C_R: aluop = 2'b10;
          C_I: begin
            aluop  = 2'b11;
            ALUSrc = 1'b1;
          end
          C_L, C_S: ALUSrc = 1'b1;
          C_B: begin
            aluop    = 2'b01;
            Branch   = w_taken;
            pc_write = 1'b1;
          end
          C_JAL: JALflag = 1'b1;
          C_JALR: begin
            JALRflag = 1'b1;
            ALUSrc   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        MemRead  = (r_cls == C_L);
        MemWrite = (r_cls == C_S);
        pc_write = (r_cls == C_S) && dmem_ready;
      end
      S_WB: begin
        RegWrite = 1'b1;
        pc_write = 1'b1;
        MemtoReg = (r_cls == C_L);
        JALflag  = (r_cls == C_JAL);
        JALRflag = (r_cls == C_JALR);
      end
      S_HALT: halt = 1'b1;
      default: ;
    endcase
  end

  assign fault = r_fault;

`ifdef MCU_PERF_COUNTERS_EN
  logic [31:0] r_instret;
  logic [31:0] r_stall;

  // Strobes and requests are all low in HALT, so both counters freeze there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
      r_stall   <= '0;
    end else begin
      if (pc_write) r_instret <= r_instret + 32'd1;
      if ((imem_req && !imem_ready) || (dmem_req && !dmem_ready))
        r_stall <= r_stall + 32'd1;
    end
  end

  assign instret_cnt = r_instret;
  assign stall_cnt   = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_control_unit
// Brief   : Randomized scoreboard bench for multicycle_control_unit.
// Revision: 1.0
// ============================================================================
module tb_multicycle_control_unit;

  localparam int TO  = 16;
  localparam int RPW = 1;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // Bit positions in the packed control vector
  localparam int B_IREQ = 15, B_DREQ = 14, B_BR = 11, B_MR = 10, B_M2R = 9;
  localparam int B_MW = 8, B_ASRC = 7, B_RW = 6, B_JAL = 5, B_JALR = 4;
  localparam int B_PCW = 3, B_IRW = 2, B_HALT = 1, B_FLT = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] instr = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, dmem_req, Branch, MemRead, MemtoReg, MemWrite, ALUSrc;
  logic       RegWrite, JALflag, JALRflag, pc_write, ir_write, halt, fault;
  logic [1:0] aluop;
`ifdef MCU_PERF_COUNTERS_EN
  logic [31:0] instret_cnt, stall_cnt;
`endif

  multicycle_control_unit #(
    .MEM_TIMEOUT(TO), .CNT_W(8), .RESET_PC_WAIT(RPW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .funct3(funct3), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .aluop(aluop), .Branch(Branch),
    .MemRead(MemRead), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .JALflag(JALflag), .JALRflag(JALRflag),
    .pc_write(pc_write), .ir_write(ir_write), .halt(halt), .fault(fault)
`ifdef MCU_PERF_COUNTERS_EN
    , .instret_cnt(instret_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] w_act;
  assign w_act = {imem_req, dmem_req, aluop, Branch, MemRead, MemtoReg, MemWrite,
                  ALUSrc, RegWrite, JALflag, JALRflag, pc_write, ir_write, halt, fault};

  typedef struct {
    logic [15:0] vec;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = '0;
  logic [31:0] exp_stall = '0;

  // Monitor: one expected control vector per clock cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (w_act !== e.vec) begin
        errors++;
        $display("FAIL ctl id=%0d t=%0t got=%h exp=%h", e.id, $time, w_act, e.vec);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_S, OP_L, OP_B, OP_JAL, OP_JALR};
  endfunction

  task automatic step(input logic [15:0] v, input logic ir, input logic dr, input int id);
    exp_t e;
    imem_ready = ir;
    dmem_ready = dr;
    e.vec = v;
    e.id  = id;
    exp_q.push_back(e);
    if (v[B_PCW]) exp_instret = exp_instret + 32'd1;
    if ((v[B_IREQ] && !ir) || (v[B_DREQ] && !dr)) exp_stall = exp_stall + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [15:0] got, input logic [15:0] want, input int id);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL direct id=%0d got=%h exp=%h", id, got, want);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk(w_act, 16'h0000, 900);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_instret = '0;
    exp_stall   = '0;
    for (int i = 0; i < 1 + RPW; i++) step(16'h0000, rb(), rb(), 901);
  endtask

  task automatic halted_cycles(input int n, input int id);
    logic [15:0] v;
    v = '0;
    v[B_HALT] = 1'b1;
    v[B_FLT]  = 1'b1;
    for (int i = 0; i < n; i++) step(v, rb(), rb(), id);
  endtask

  // Reference: expected per-cycle controls for one instruction, from class rules
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input int iw, input int dw, input int id, output logic halted);
    logic [15:0] v;
    logic is_ld, is_st;
    halted = 1'b0;
    instr  = op;
    funct3 = f3;
    zero   = z;
    for (int k = 0; k < iw && k < TO; k++) begin
      v = '0; v[B_IREQ] = 1'b1;
      step(v, 1'b0, rb(), id);
    end
    if (iw >= TO) begin halted = 1'b1; return; end
    v = '0; v[B_IREQ] = 1'b1; v[B_IRW] = 1'b1;
    step(v, 1'b1, rb(), id);
    step(16'h0000, rb(), rb(), id);
    if (!legal(op)) begin halted = 1'b1; return; end
    is_ld = (op == OP_L);
    is_st = (op == OP_S);
    v = '0;
    case (op)
      OP_R: v[13:12] = 2'b10;
      OP_I: begin v[13:12] = 2'b11; v[B_ASRC] = 1'b1; end
      OP_L, OP_S: v[B_ASRC] = 1'b1;
      OP_B: begin
        v[13:12] = 2'b01;
        v[B_BR]  = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
        v[B_PCW] = 1'b1;
      end
      OP_JAL: v[B_JAL] = 1'b1;
      default: begin v[B_JALR] = 1'b1; v[B_ASRC] = 1'b1; end
    endcase
    step(v, rb(), rb(), id);
    if (op == OP_B) return;
    if (is_ld || is_st) begin
      for (int k = 0; k < dw && k < TO; k++) begin
        v = '0; v[B_DREQ] = 1'b1; v[B_MR] = is_ld; v[B_MW] = is_st;
        step(v, rb(), 1'b0, id);
      end
      if (dw >= TO) begin halted = 1'b1; return; end
      v = '0; v[B_DREQ] = 1'b1; v[B_MR] = is_ld; v[B_MW] = is_st; v[B_PCW] = is_st;
      step(v, rb(), 1'b1, id);
      if (is_st) return;
    end
    v = '0;
    v[B_RW]   = 1'b1;
    v[B_PCW]  = 1'b1;
    v[B_M2R]  = is_ld;
    v[B_JAL]  = (op == OP_JAL);
    v[B_JALR] = (op == OP_JALR);
    step(v, rb(), rb(), id);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops[7];
    logic       h;
    int         iw, dw;
    ops = '{OP_R, OP_I, OP_S, OP_L, OP_B, OP_JAL, OP_JALR};

    #3;
    chk(w_act, 16'h0000, 0);
    @(posedge clk);
    #1;
    do_reset();

    // Directed instructions
    run_instr(OP_R,    3'b000, 1'b0, 0, 0, 1, h);
    run_instr(OP_L,    3'b010, 1'b0, 0, 3, 2, h);
    run_instr(OP_B,    3'b000, 1'b1, 0, 0, 3, h);
    run_instr(OP_B,    3'b001, 1'b1, 0, 0, 4, h);
    run_instr(OP_B,    3'b001, 1'b0, 1, 0, 5, h);
    run_instr(OP_S,    3'b010, 1'b0, 2, 0, 6, h);
    run_instr(OP_JAL,  3'b000, 1'b0, 0, 0, 7, h);
    run_instr(OP_JALR, 3'b000, 1'b0, 0, 0, 8, h);
    run_instr(OP_I,    3'b000, 1'b0, 0, 0, 9, h);

    // Random legal traffic
    for (int n = 0; n < 60; n++) begin
      iw = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
      dw = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
      run_instr(ops[$urandom_range(0, 6)], 3'($urandom_range(0, 7)), rb(), iw, dw, 100 + n, h);
    end

    // Last-cycle ready on both memories still succeeds
    run_instr(OP_L, 3'b010, 1'b0, TO - 1, TO - 1, 200, h);
    run_instr(OP_S, 3'b010, 1'b0, TO - 1, TO - 1, 201, h);

`ifdef MCU_PERF_COUNTERS_EN
    checks++;
    if (instret_cnt !== exp_instret) begin
      errors++;
      $display("FAIL instret got=%0d exp=%0d", instret_cnt, exp_instret);
    end
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++;
      $display("FAIL stall got=%0d exp=%0d", stall_cnt, exp_stall);
    end
`endif

    // Fetch timeout
    run_instr(OP_R, 3'b000, 1'b0, TO, 0, 300, h);
    halted_cycles(6, 301);

    // Data memory timeout
    do_reset();
    run_instr(OP_S, 3'b000, 1'b0, 0, TO, 400, h);
    halted_cycles(4, 401);

    // Illegal opcode, then async reset while halted
    do_reset();
    run_instr(7'b0000000, 3'b000, 1'b0, 0, 0, 500, h);
    halted_cycles(4, 501);
`ifdef MCU_PERF_COUNTERS_EN
    checks++;
    if (instret_cnt !== exp_instret || stall_cnt !== exp_stall) begin
      errors++;
      $display("FAIL perf_halt got=%0d/%0d exp=%0d/%0d", instret_cnt, stall_cnt,
               exp_instret, exp_stall);
    end
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk(w_act, 16'h0000, 502);
    @(posedge clk);
    #1;
    do_reset();

    // Async reset mid-fetch drops the request
    imem_ready = 1'b0;
    #1;
    chk({15'd0, imem_req}, 16'h0001, 600);
    #1;
    rst_n = 1'b0;
    #1;
    chk(w_act, 16'h0000, 601);
    @(posedge clk);
    #1;
    do_reset();
    run_instr(OP_I, 3'b000, 1'b0, 0, 0, 700, h);

    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle successor to the single-cycle control unit; sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB.
- Talks to instruction and data memories over req/ready handshakes with bounded, parametrised wait states.
- Drives the existing datapath control set (aluop, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, JALflag, JALRflag, halt) plus per-state strobes pc_write and ir_write.
- Sits between the datapath and the memory wrappers.

Parameters:
- MEM_TIMEOUT, 16, max cycles a req waits for ready before fault halt; legal range 1..255.
- CNT_W, 8, width of the internal wait counter; must hold MEM_TIMEOUT.
- RESET_PC_WAIT, 1, idle cycles after reset release before the first FETCH; 0 allowed.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  7  opcode of the current IR, sampled in DECODE
- funct3  in  3  funct3 of the current IR, sampled in DECODE
- zero  in  1  ALU zero flag, valid in EXEC
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- aluop  out  2  00 add, 01 sub/compare, 10 R-type funct decode, 11 I-type funct decode
- Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, JALflag, JALRflag  out  1 each  datapath controls, same meaning as the single-cycle unit
- pc_write  out  1  PC update strobe, one cycle per instruction
- ir_write  out  1  IR load strobe
- halt  out  1  sticky halt
- fault  out  1  sticky; set with halt on timeout or illegal opcode

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is free; state is registered, outputs are Moore decode of state plus latched opcode/funct3.
- Reset (rst_n low, async): state=IDLE, wait counter=0. Every output is 0 (imem_req, dmem_req, all controls, pc_write, ir_write, halt, fault).
- IDLE: counts RESET_PC_WAIT cycles, then goes to FETCH. If RESET_PC_WAIT=0, goes to FETCH on the first clk after reset release.
- FETCH: imem_req=1, counter increments each cycle.
  - imem_ready=1: ir_write=1 that cycle, next state DECODE, counter cleared.
  - Counter reaches MEM_TIMEOUT with no ready: HALT with fault=1.
- DECODE: latch instr and funct3. Opcode classes: R 0110011, I 0010011, S 0100011, L 0000011, B 1100011, JAL 1101111, JALR 1100111. Any other opcode, including 0000000, goes to HALT with fault=1. Otherwise next state is EXEC.
- EXEC: aluop and ALUSrc per class.
  - R: aluop=10, ALUSrc=0, next WB.
  - I: aluop=11, ALUSrc=1, next WB.
  - L/S: aluop=00, ALUSrc=1, next MEM.
  - B: aluop=01, ALUSrc=0, Branch=1, pc_write=1, next FETCH. Branch taken = (funct3==000 & zero) | (funct3==001 & ~zero); any other funct3 is not taken. Datapath selects target using Branch & taken, presented on Branch only when taken.
  - JAL: JALflag=1. JALR: JALRflag=1, ALUSrc=1, aluop=00. Both next WB.
- MEM: dmem_req=1; MemRead=1 for L, MemWrite=1 for S; both held stable until ready.
  - dmem_ready=1: L goes to WB; S sets pc_write=1 and goes to FETCH.
  - Timeout rule identical to FETCH.
- WB: RegWrite=1 and pc_write=1 for one cycle; MemtoReg=1 for L only; JALflag/JALRflag held for J-types. Next FETCH.
- HALT: absorbing; only rst_n exits. halt=1; all req, write and strobe outputs are 0.
- Simultaneous events: ready arriving in the same cycle the counter hits MEM_TIMEOUT counts as success.
- Ready is ignored in states that do not issue the matching req.
- Reset asserted mid-access drops req asynchronously.
- Latency: R/I/JAL/JALR = 4 cycles + imem waits; L = 5 + waits; S = 4 + waits; B = 3 + waits.

Optional Feature:
- Macro: MCU_PERF_COUNTERS_EN.
- Defined: adds outputs instret_cnt[31:0] and stall_cnt[31:0].
  - instret_cnt increments on each pc_write.
  - stall_cnt increments on each FETCH/MEM cycle with req=1 and ready=0.
  - Both wrap modulo 2^32, reset to 0, and freeze in HALT.
- Not defined: neither port nor counter exists; all other behaviour identical.

Test Plan:
- Reset then R-type 0110011, imem_ready=1 in the first FETCH cycle → sequence FETCH, DECODE, EXEC (aluop=10), WB (RegWrite=1, pc_write=1); next FETCH at cycle 5 after IDLE.
- Load 0000011 with dmem_ready delayed 3 cycles → MemRead=1 held 4 cycles; WB has MemtoReg=1 and RegWrite=1.
- BEQ (funct3=000) with zero=1 → Branch=1, pc_write=1 in EXEC. BNE with zero=1 → Branch=0, pc_write=1. Neither asserts RegWrite.
- imem_ready held 0, MEM_TIMEOUT=16 → halt=1, fault=1 after 16 FETCH cycles; stays set until rst_n low.
- Opcode 0000000 → HALT with fault=1 from DECODE. A later rst_n pulse clears every output to 0 asynchronously.
- With MCU_PERF_COUNTERS_EN: 3 instructions with 2 stall cycles total → instret_cnt=3, stall_cnt=2.
